// File: rtl/tl_phase_sched.sv
// Traffic-light phase scheduler: four road phases plus a pedestrian walk,
// served round-robin on demand with minimum/maximum green timing.
//
// state  | meaning
// GREEN  | served phase has right of way (or walk if phase=P4 is in WALK)
// YELLOW | served road's lamp is yellow, next phase already latched
// ALLRED | clearance, both roads red; phase still shows the previous phase
// WALK   | pedestrian phase P4, both roads red, walk lamp on
module tl_phase_sched #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  input  logic       ped_req,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2,
    S_WALK   = 2'd3
  } state_t;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;
  localparam logic [1:0] LAMP_LEFT   = 2'b11;

  localparam logic [7:0] GMIN_M1 = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_M1 = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YEL_M1  = 8'(YELLOW_T - 1);
  localparam logic [7:0] ARED_M1 = 8'(ALLRED_T - 1);
  localparam logic [7:0] WALK_M1 = 8'(WALK_T - 1);
  localparam logic [2:0] PH_WALK = 3'd4;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_timer;
  logic [2:0] r_phase;
  logic [2:0] w_phase_nxt;
  logic [2:0] r_next_phase;
  logic [2:0] w_next_phase_nxt;
  logic       r_ped_pend;
  logic [7:0] w_dem;
  logic       w_own_dem;
  logic       w_cand_vld;
  logic [2:0] w_cand;
  logic [2:0] w_idx;
  logic       w_green_exit;
  logic       w_state_chg;

  // Demand per phase; upper bits pad the vector so any 3-bit index is legal.
  assign w_dem     = {3'b000, r_ped_pend, Tbl, Tb, Tal, Ta};
  assign w_own_dem = w_dem[r_phase];

  // Round-robin candidate: scan from farthest to nearest so the nearest
  // demanding phase after the current one wins; the current phase is skipped.
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand     = 3'd0;
    w_idx      = 3'd0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = 3'((int'(r_phase) + k) % 5);
      if (w_dem[w_idx]) begin
        w_cand_vld = 1'b1;
        w_cand     = w_idx;
      end
    end
  end

  // The max-green cap uses >= so demand arriving after a long rest still
  // ends a green whose own demand never drops.
  assign w_green_exit = (r_timer >= GMIN_M1) && w_cand_vld &&
                        (!w_own_dem || (r_timer >= GMAX_M1));

  // Next-state, next served phase and latched candidate.
  always_comb begin
    w_state_nxt      = r_state;
    w_phase_nxt      = r_phase;
    w_next_phase_nxt = r_next_phase;
    case (r_state)
      S_GREEN: begin
        if (w_green_exit) begin
          w_state_nxt      = S_YELLOW;
          w_next_phase_nxt = w_cand;
        end
      end
      S_YELLOW: begin
        if (r_timer == YEL_M1) w_state_nxt = S_ALLRED;
      end
      S_ALLRED: begin
        if (r_timer == ARED_M1) begin
          w_state_nxt = (r_next_phase == PH_WALK) ? S_WALK : S_GREEN;
          w_phase_nxt = r_next_phase;
        end
      end
      S_WALK: begin
        if (r_timer == WALK_M1) begin
          w_state_nxt      = S_ALLRED;
          w_next_phase_nxt = w_cand_vld ? w_cand : 3'd0;
        end
      end
      default: w_state_nxt = S_GREEN;
    endcase
  end

  assign w_state_chg = (w_state_nxt != r_state);

  // State, phase and timer registers; timer restarts on every state entry
  // and saturates while green rests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_GREEN;
      r_phase      <= 3'd0;
      r_next_phase <= 3'd0;
      r_timer      <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_next_phase <= w_next_phase_nxt;
      if (w_state_chg)           r_timer <= 8'd0;
      else if (r_timer != 8'hFF) r_timer <= r_timer + 8'd1;
    end
  end

  // Pedestrian latch: a request in the walk-entry cycle wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                      r_ped_pend <= 1'b0;
    else if (ped_req)                                  r_ped_pend <= 1'b1;
    else if (w_state_chg && (w_state_nxt == S_WALK))   r_ped_pend <= 1'b0;
  end

  // Lamp decode from registered state and phase only.
  always_comb begin
    La   = LAMP_RED;
    Lb   = LAMP_RED;
    walk = 1'b0;
    case (r_state)
      S_GREEN: begin
        case (r_phase)
          3'd0:    La = LAMP_GREEN;
          3'd1:    La = LAMP_LEFT;
          3'd2:    Lb = LAMP_GREEN;
          3'd3:    Lb = LAMP_LEFT;
          default: ;
        endcase
      end
      S_YELLOW: begin
        if (r_phase <= 3'd1)      La = LAMP_YELLOW;
        else if (r_phase <= 3'd3) Lb = LAMP_YELLOW;
      end
      S_WALK:  walk = 1'b1;
      default: ;
    endcase
  end

  assign phase = r_phase;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Directed bench for tl_phase_sched; expected lamp sequences are hand-derived
// edge by edge, edge 1 being the first rising edge after reset release.
module tb_tl_phase_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       Ta = 1'b0, Tal = 1'b0, Tb = 1'b0, Tbl = 1'b0, ped_req = 1'b0;
  logic [1:0] La, Lb;
  logic       walk;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] obs, exp_v;

  tl_phase_sched dut (
    .clk(clk), .reset_n(reset_n), .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
    .ped_req(ped_req), .La(La), .Lb(Lb), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pk(input logic [1:0] la, input logic [1:0] lb,
                                    input logic w, input logic [2:0] ph);
    return {la, lb, w, ph};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    Ta = 1'b0; Tal = 1'b1; Tb = 1'b1; Tbl = 1'b0; ped_req = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {La, Lb, walk, phase};
    n_checks++;
    if (obs !== pk(2'b00, 2'b10, 1'b0, 3'd0)) begin
      n_errors++;
      $display("FAIL reset_values got %b expected %b", obs, pk(2'b00, 2'b10, 1'b0, 3'd0));
    end
    ped_req = 1'b0;
  endtask

  task automatic test_p0_rest();
    Ta = 1'b1; Tal = 1'b0; Tb = 1'b0; Tbl = 1'b0; ped_req = 1'b0;
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k <= 60) begin
        obs = {La, Lb, walk, phase};
        n_checks++;
        if (obs !== pk(2'b00, 2'b10, 1'b0, 3'd0)) begin
          n_errors++;
          $display("FAIL p0_rest edge %0d got %b expected %b", k, obs, pk(2'b00, 2'b10, 1'b0, 3'd0));
        end
      end
    end
    // Timer is saturated here; a wrapped timer would be 0 and miss GREEN_MIN.
    Ta = 1'b0; Tb = 1'b1;
    tick();
    obs = {La, Lb, walk, phase};
    n_checks++;
    if (obs !== pk(2'b01, 2'b10, 1'b0, 3'd0)) begin
      n_errors++;
      $display("FAIL timer_saturate got %b expected %b", obs, pk(2'b01, 2'b10, 1'b0, 3'd0));
    end
  endtask

  task automatic test_b_only();
    Ta = 1'b0; Tal = 1'b0; Tb = 1'b1; Tbl = 1'b0; ped_req = 1'b0;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 3)      exp_v = pk(2'b00, 2'b10, 1'b0, 3'd0);
      else if (k <= 5) exp_v = pk(2'b01, 2'b10, 1'b0, 3'd0);
      else if (k == 6) exp_v = pk(2'b10, 2'b10, 1'b0, 3'd0);
      else             exp_v = pk(2'b10, 2'b00, 1'b0, 3'd2);
      obs = {La, Lb, walk, phase};
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL b_only edge %0d got %b expected %b", k, obs, exp_v);
      end
      // Demand moves to P3 during yellow; the latched choice P2 must stand.
      if (k == 4) begin Tb = 1'b0; Tbl = 1'b1; end
    end
  endtask

  task automatic test_left();
    Ta = 1'b1; Tal = 1'b1; Tb = 1'b0; Tbl = 1'b0; ped_req = 1'b0;
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k <= 11)      exp_v = pk(2'b00, 2'b10, 1'b0, 3'd0);
      else if (k <= 13) exp_v = pk(2'b01, 2'b10, 1'b0, 3'd0);
      else if (k == 14) exp_v = pk(2'b10, 2'b10, 1'b0, 3'd0);
      else if (k <= 18) exp_v = pk(2'b11, 2'b10, 1'b0, 3'd1);
      else if (k <= 20) exp_v = pk(2'b01, 2'b10, 1'b0, 3'd1);
      else if (k == 21) exp_v = pk(2'b10, 2'b10, 1'b0, 3'd1);
      else              exp_v = pk(2'b10, 2'b00, 1'b0, 3'd2);
      obs = {La, Lb, walk, phase};
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL left_max edge %0d got %b expected %b", k, obs, exp_v);
      end
      if (k == 15) begin Ta = 1'b0; Tal = 1'b0; Tb = 1'b1; end
    end
  endtask

  task automatic test_ped();
    Ta = 1'b0; Tal = 1'b0; Tb = 1'b1; Tbl = 1'b0; ped_req = 1'b0;
    do_reset();
    repeat (7) tick();
    ped_req = 1'b1;
    for (int k = 8; k <= 31; k++) begin
      tick();
      if (k == 8) begin ped_req = 1'b0; Tb = 1'b0; end
      if (k <= 10)      exp_v = pk(2'b10, 2'b00, 1'b0, 3'd2);
      else if (k <= 12) exp_v = pk(2'b10, 2'b01, 1'b0, 3'd2);
      else if (k == 13) exp_v = pk(2'b10, 2'b10, 1'b0, 3'd2);
      else if (k <= 19) exp_v = pk(2'b10, 2'b10, 1'b1, 3'd4);
      else if (k == 20) exp_v = pk(2'b10, 2'b10, 1'b0, 3'd4);
      else              exp_v = pk(2'b11, 2'b10, 1'b0, 3'd1);
      obs = {La, Lb, walk, phase};
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL ped_walk edge %0d got %b expected %b", k, obs, exp_v);
      end
      if (k == 14) Tal = 1'b1;
      if (k == 21) Tal = 1'b0;
    end
  endtask

  task automatic test_skip();
    Ta = 1'b0; Tal = 1'b0; Tb = 1'b0; Tbl = 1'b1; ped_req = 1'b0;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 3)      exp_v = pk(2'b00, 2'b10, 1'b0, 3'd0);
      else if (k <= 5) exp_v = pk(2'b01, 2'b10, 1'b0, 3'd0);
      else if (k == 6) exp_v = pk(2'b10, 2'b10, 1'b0, 3'd0);
      else             exp_v = pk(2'b10, 2'b11, 1'b0, 3'd3);
      obs = {La, Lb, walk, phase};
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL skip edge %0d got %b expected %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_walk_default();
    Ta = 1'b0; Tal = 1'b0; Tb = 1'b0; Tbl = 1'b0; ped_req = 1'b0;
    do_reset();
    ped_req = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      ped_req = (k == 6);
      if (k <= 3)       exp_v = pk(2'b00, 2'b10, 1'b0, 3'd0);
      else if (k <= 5)  exp_v = pk(2'b01, 2'b10, 1'b0, 3'd0);
      else if (k == 6)  exp_v = pk(2'b10, 2'b10, 1'b0, 3'd0);
      else if (k <= 12) exp_v = pk(2'b10, 2'b10, 1'b1, 3'd4);
      else if (k == 13) exp_v = pk(2'b10, 2'b10, 1'b0, 3'd4);
      else if (k <= 17) exp_v = pk(2'b00, 2'b10, 1'b0, 3'd0);
      else              exp_v = pk(2'b01, 2'b10, 1'b0, 3'd0);
      obs = {La, Lb, walk, phase};
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL walk_default edge %0d got %b expected %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    Ta = 1'b0; Tal = 1'b0; Tb = 1'b1; Tbl = 1'b0; ped_req = 1'b0;
    do_reset();
    repeat (7) tick();
    ped_req = 1'b1; Tb = 1'b0; Tbl = 1'b1;
    tick();
    ped_req = 1'b0;
    repeat (3) tick();
    obs = {La, Lb, walk, phase};
    n_checks++;
    if (obs !== pk(2'b10, 2'b01, 1'b0, 3'd2)) begin
      n_errors++;
      $display("FAIL mid_yellow_pre got %b expected %b", obs, pk(2'b10, 2'b01, 1'b0, 3'd2));
    end
    #1 reset_n = 1'b0;
    #1;
    obs = {La, Lb, walk, phase};
    n_checks++;
    if (obs !== pk(2'b00, 2'b10, 1'b0, 3'd0)) begin
      n_errors++;
      $display("FAIL async_reset got %b expected %b", obs, pk(2'b00, 2'b10, 1'b0, 3'd0));
    end
    Tbl = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    // A surviving ped latch would pull P0 into yellow at edge 4.
    for (int k = 1; k <= 10; k++) begin
      tick();
      obs = {La, Lb, walk, phase};
      n_checks++;
      if (obs !== pk(2'b00, 2'b10, 1'b0, 3'd0)) begin
        n_errors++;
        $display("FAIL ped_cleared edge %0d got %b expected %b", k, obs, pk(2'b00, 2'b10, 1'b0, 3'd0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_p0_rest();
    test_b_only();
    test_left();
    test_ped();
    test_skip();
    test_walk_default();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tl_phase_sched.md
TL_PHASE_SCHED -- requirements
Module: tl_phase_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk.
REQ-002 Parameters (one per line: name, default, meaning):
- GREEN_MIN, 4: minimum green length in cycles.
- GREEN_MAX, 12: maximum green length when other demand is waiting.
- YELLOW_T, 2: yellow length in cycles.
- ALLRED_T, 1: all-red clearance length in cycles.
- WALK_T, 6: pedestrian walk length in cycles.
- All parameters SHALL be in the range 1..255, and GREEN_MIN SHALL be <= GREEN_MAX.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset_n, in, 1: asynchronous active-low reset.
- Ta, in, 1: traffic present on A straight.
- Tal, in, 1: traffic present on A left.
- Tb, in, 1: traffic present on B straight.
- Tbl, in, 1: traffic present on B left.
- ped_req, in, 1: pedestrian button; a 1-cycle pulse is sufficient.
- La, out, 2: road A lamp.
- Lb, out, 2: road B lamp.
- walk, out, 1: pedestrian walk lamp.
- phase, out, 3: current phase, 0..4.
REQ-004 Lamp encoding SHALL be: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED, 2'b11 LEFT-arrow.

Function
REQ-005 Phases SHALL be:
- P0: A straight, La=GREEN.
- P1: A left, La=LEFT.
- P2: B straight, Lb=GREEN.
- P3: B left, Lb=LEFT.
- P4: pedestrian walk, La=Lb=RED, walk=1.
- The non-served road SHALL be RED in every phase.
REQ-006 The FSM SHALL have states GREEN, YELLOW, ALLRED and WALK, with a timer cleared to 0 on every state entry and incremented by 1 each cycle.
REQ-007 Demand SHALL be defined per phase: P0=Ta, P1=Tal, P2=Tb, P3=Tbl, P4=ped_pend.
REQ-008 The ped_pend latch SHALL be set by ped_req=1 and cleared on entry to WALK; a ped_req in the WALK entry cycle SHALL leave ped_pend set.
REQ-009 Next-phase selection SHALL be round-robin starting after the current phase (P0>P1>P2>P3>P4>P0), taking the first phase with demand and excluding the current phase; "no candidate" means no other phase has demand.
REQ-010 GREEN SHALL exit at the clock edge where all of the following hold:
- timer >= GREEN_MIN-1;
- a candidate exists;
- the own demand is 0, or timer == GREEN_MAX-1.
REQ-011 With no candidate, GREEN SHALL rest indefinitely; the timer SHALL saturate at 255 and never wrap.
REQ-012 The candidate SHALL be registered into next_phase at GREEN exit and held until the next GREEN/WALK entry; demand changes during YELLOW/ALLRED SHALL NOT alter it.
REQ-013 During YELLOW (exactly YELLOW_T cycles), the served road's lamp SHALL be YELLOW for both straight and left phases.
REQ-014 ALLRED SHALL last exactly ALLRED_T cycles with La=Lb=RED and walk=0, then SHALL enter GREEN (or WALK if next_phase=P4) with phase=next_phase.
REQ-015 WALK SHALL last exactly WALK_T cycles regardless of demand, then go directly to ALLRED (no yellow), with next_phase selected as in REQ-009 from P4; if no candidate exists, next_phase SHALL be P0.
REQ-016 phase SHALL show the currently served phase in GREEN/YELLOW/WALK and the previous phase during ALLRED.
REQ-017 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from any input to any output.

Reset
REQ-018 While reset_n=0, the block SHALL asynchronously force: state=GREEN, phase=0, timer=0, next_phase=0, ped_pend=0, La=GREEN, Lb=RED, walk=0.
REQ-019 Reset asserted mid-operation in any state SHALL immediately return the block to the REQ-018 values.
REQ-020 After reset release, the first rising edge SHALL count as P0 GREEN timer=0.

Verification
REQ-021 Reset release with Ta=1 and all other inputs 0 -> P0 green holds for 50+ cycles, La=00, Lb=10.
REQ-022 Reset release with Ta=0, Tb=1 -> 4 cycles La=00, 2 cycles La=01, 1 cycle all-red, then Lb=00 and phase=2 on cycle 8.
REQ-023 Ta=Tal=1 held -> La=00 for exactly 12 cycles, La=01 for 2, all-red 1, then La=11 with phase=1.
REQ-024 In P2 green with Tb=1, pulse ped_req once and then drop Tb -> yellow 2, all-red 1, walk=1 with La=Lb=10 for 6 cycles, all-red 1, then next demanded phase.
REQ-025 Skipping: in P0, Ta=0, Tal=0, Tbl=1 -> P1 and P2 skipped, phase=3 with Lb=11 after yellow/all-red.
REQ-026 Assert reset_n=0 mid-YELLOW of P2 -> same-cycle La=00, Lb=10, walk=0, phase=0, and ped_pend cleared.
